fetch_stage: RTL and testbench

Instruction fetch stage of the pipelined RISC-V core, directly upstream of the decode stage. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready channel. It buffers in-order responses in a small FIFO and presents {pc, instr} packets to decode over a valid/ready channel. A redirect from execute (branch/jump) flushes all in-flight and buffered fetches and restarts at the new PC.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_fifo.sv | 40 ++++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Core-wide constants and the fetch-to-decode packet type shared across the pipeline.
package cpu_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side channels.
interface fetch_stage_if
    import cpu_pkg::*;
;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} packets; flush empties it in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_pkt_t                   push_pkt,
    input  logic                         pop,
    output fetch_pkt_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_pkt_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_pkt;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests and buffers
// in-order responses for decode; a redirect squashes everything older.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    fetch_stage_if.master  bus
);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_base;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   outstanding_next;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            resp_fire;
    logic            keep;
    logic            pop;
    fetch_pkt_t      push_pkt;
    fetch_pkt_t      head;

    assign credit_used       = {1'b0, in_flight} + {1'b0, fifo_count};
    assign bus.imem_req_valid = !reset && (credit_used < (CW+1)'(BUF_DEPTH));
    assign bus.imem_req_addr  = pc;
    assign redirect_base      = bus.redirect_pc & ~XLEN'(3);

    assign req_fire         = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_fire        = bus.imem_resp_valid;
    assign outstanding_next = in_flight + CW'(req_fire) - CW'(resp_fire);
    assign keep             = resp_fire && (drop == '0) && !bus.redirect_valid;

    assign bus.out_valid = !reset && (fifo_count != '0);
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign pop           = bus.out_valid && bus.out_ready;

    // Kept responses are always a contiguous run starting at the last restart
    // address, so a single running PC replaces a FIFO of issued addresses.
    assign push_pkt = '{pc: resp_pc, instr: bus.imem_resp_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            drop      <= '0;
        end else begin
            in_flight <= outstanding_next;
            if (bus.redirect_valid) begin
                pc      <= redirect_base;
                resp_pc <= redirect_base;
                drop    <= outstanding_next;
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (keep) resp_pc <= resp_pc + XLEN'(4);
                if (resp_fire && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.redirect_valid),
        .push     (keep),
        .push_pkt (push_pkt),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: an in-order memory model with epoch tags feeds
// a scoreboard of expected {pc, instr} packets checked by an independent monitor.
`timescale 1ns/1ps
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    fetch_pkt_t  exp_q[$];
    logic [31:0] out_log[$];
    logic [31:0] acc_log[$];

    int          cyc = 0;
    int unsigned epoch = 0;
    logic [31:0] model_pc = RST_PC;
    int          checks = 0;
    int          errors = 0;
    int          lat_k = 1, jitter = 0;
    int          p_req = 100, p_out = 100, p_resp = 100;
    int          first_acc = -1, first_val = -1;
    logic        prev_rst = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic knobs(input int k, input int j, input int pq, input int po, input int pr);
        lat_k = k; jitter = j; p_req = pq; p_out = po; p_resp = pr;
    endtask

    // One clock of stimulus plus the memory side of the reference model.
    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc);
        bit    give;
        mreq_t m;
        mreq_t r;
        @(negedge clk);
        reset              = rst;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = ($urandom_range(99) < p_req);
        bus.out_ready      = ($urandom_range(99) < p_out);
        give = !rst && (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < p_resp);
        bus.imem_resp_valid = give;
        bus.imem_resp_data  = give ? mq[0].data : $urandom;
        #1;
        if (rst) begin
            check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        end else if (prev_rst) begin
            check("post_rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
            check("post_rst_req_addr", 64'(bus.imem_req_addr), 64'(RST_PC));
            check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        end
        prev_rst = rst;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", 64'(bus.imem_req_addr), 64'(model_pc));
            if (first_acc < 0) first_acc = cyc;
            acc_log.push_back(bus.imem_req_addr);
            m.addr  = model_pc;
            m.data  = $urandom;
            m.epoch = epoch;
            m.due   = cyc + lat_k + int'($urandom_range(jitter));
            mq.push_back(m);
            model_pc = model_pc + 32'd4;
        end
        if (give) begin
            r = mq.pop_front();
            if (r.epoch == epoch && !redir)
                exp_q.push_back('{pc: r.addr, instr: r.data});
        end
        #2;
        if (rst) begin
            mq.delete(); exp_q.delete(); out_log.delete(); acc_log.delete();
            epoch++;
            model_pc  = RST_PC;
            first_acc = -1;
            first_val = -1;
        end else if (redir) begin
            exp_q.delete(); out_log.delete(); acc_log.delete();
            epoch++;
            model_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: consumes the expected stream whenever decode accepts a packet.
    initial begin
        fetch_pkt_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.out_valid === 1'b1 && first_val < 0) first_val = cyc;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got pc %h, expected no packet", bus.out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", 64'(bus.out_pc), 64'(e.pc));
                    check("out_instr", 64'(bus.out_instr), 64'(e.instr));
                end
                out_log.push_back(bus.out_pc);
            end
        end
    end

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b0;

        // Streaming with single-cycle memory
        knobs(1, 0, 100, 100, 100);
        do_reset(2);
        run(10);
        check("first_latency", 64'(first_val - first_acc), 64'd2);
        check("stream_len_ok", 64'(out_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++)
            check("stream_pc", 64'(out_log[i]), 64'(32'(i * 4)));

        // Decode stalled: credits cap issue at DEPTH
        knobs(1, 0, 100, 0, 100);
        do_reset(2);
        run(5);
        check("stall_issued", 64'(acc_log.size()), 64'(DEPTH));
        check("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_out_pc", 64'(bus.out_pc), 64'h0);
        p_out = 100;
        run(10);
        check("stall_resume0", 64'(out_log[0]), 64'h0);
        check("stall_resume1", 64'(out_log[1]), 64'h4);

        // Redirect with two long-latency fetches outstanding
        knobs(3, 0, 100, 100, 100);
        do_reset(2);
        run(2);
        step(1'b0, 1'b1, 32'h0000_0103);
        run(14);
        check("redir_req_addr", 64'(acc_log[0]), 64'h100);
        check("redir_out_pc", 64'(out_log[0]), 64'h100);

        // Redirect coinciding with a response and a request handshake
        knobs(1, 0, 100, 100, 100);
        do_reset(2);
        run(1);
        step(1'b0, 1'b1, 32'h0000_0200);
        run(10);
        check("coinc_req_addr", 64'(acc_log[0]), 64'h200);
        check("coinc_out_pc0", 64'(out_log[0]), 64'h200);
        check("coinc_out_pc1", 64'(out_log[1]), 64'h204);

        // Address wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        run(10);
        check("wrap_addr0", 64'(acc_log[0]), 64'hFFFF_FFFC);
        check("wrap_addr1", 64'(acc_log[1]), 64'h0);
        check("wrap_out_pc1", 64'(out_log[1]), 64'h0);

        // One-cycle reset mid-stream
        knobs(2, 2, 70, 60, 80);
        run(20);
        do_reset(1);
        run(20);

        // Random traffic with redirects and occasional resets
        for (int blk = 0; blk < 10; blk++) begin
            knobs(int'($urandom_range(4, 1)), int'($urandom_range(3)),
                  int'($urandom_range(100, 50)), int'($urandom_range(100, 30)),
                  int'($urandom_range(100, 60)));
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(399) == 0)
                    step(1'b1, 1'b0, 32'h0);
                else
                    step(1'b0, ($urandom_range(24) == 0), $urandom);
            end
        end

        // Drain: no new requests, everything outstanding must reach decode
        knobs(1, 0, 0, 100, 100);
        run(40);
        check("drain_mem_empty", 64'(mq.size()), 64'd0);
        check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
